// File: rtl/oport_arb.sv
//------------------------------------------------------------------------------
// Module   : oport_arb
// Purpose  : Per-output-port switch allocator. Round-robin arbitration among
//            requesting input ports; wormhole locking until the tail flit.
// Options  : OARB_BYPASS_EN - zero-bubble handoff to the next requester on a
//            tail release (default build inserts one IDLE cycle).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module oport_arb #(
  parameter int NREQ = 5,
  parameter int IDXW = 3,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic [NREQ-1:0] req,
  input  logic            fire,
  input  logic            tail,
  output logic [NREQ-1:0] grt,
  output logic            lock,
  output logic [IDXW-1:0] owner,
  output logic [CNTW-1:0] flit_cnt,
  output logic            err
);

  localparam logic            c_IDLE = 1'b0;
  localparam logic            c_LOCK = 1'b1;
  localparam logic [IDXW-1:0] c_LAST = IDXW'(NREQ - 1);

  logic            r_state;
  logic [IDXW-1:0] r_owner;
  logic [IDXW-1:0] r_ptr;
  logic [CNTW-1:0] r_cnt;
  logic            r_err;

  logic            w_state_nxt;
  logic [IDXW-1:0] w_owner_nxt;
  logic [IDXW-1:0] w_ptr_nxt;
  logic [CNTW-1:0] w_cnt_nxt;
  logic            w_err_nxt;

  logic [NREQ-1:0] w_own_oh;
  logic [IDXW-1:0] w_ptr_rel;
  logic [CNTW-1:0] w_cnt_inc;
  logic [IDXW-1:0] w_pick_idle;
`ifdef OARB_BYPASS_EN
  logic [NREQ-1:0] w_others;
  logic [IDXW-1:0] w_pick_byp;
`endif

  // Round-robin pick: the set bit with the smallest circular distance from
  // i_start wins, so the scan order is i_start, i_start+1, ... wrapping.
  function automatic logic [IDXW-1:0] f_pick(input logic [NREQ-1:0] i_r,
                                             input logic [IDXW-1:0] i_start);
    logic [IDXW:0]   v_d;
    logic [IDXW:0]   v_best;
    logic [IDXW-1:0] v_sel;
    v_best = '1;
    v_sel  = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (i_r[j]) begin
        if (IDXW'(j) >= i_start)
          v_d = {1'b0, IDXW'(j) - i_start};
        else
          v_d = {1'b0, IDXW'(j)} + (IDXW+1)'(NREQ) - {1'b0, i_start};
        if (v_d < v_best) begin
          v_best = v_d;
          v_sel  = IDXW'(j);
        end
      end
    end
    return v_sel;
  endfunction

  assign w_own_oh    = NREQ'(1) << r_owner;
  assign w_ptr_rel   = (r_owner == c_LAST) ? '0 : r_owner + 1'b1;
  assign w_cnt_inc   = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
  assign w_pick_idle = f_pick(req, r_ptr);
`ifdef OARB_BYPASS_EN
  // The ex-owner is masked so it is never re-granted through the bypass path.
  assign w_others    = req & ~w_own_oh;
  assign w_pick_byp  = f_pick(w_others, w_ptr_rel);
`endif

  // State register: all allocator state, asynchronously cleared.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      r_state <= c_IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state logic: grant, flit counting, release and abort handling.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    case (r_state)
      c_IDLE: begin
        if (fire)
          w_err_nxt = 1'b1;
        if (|req) begin
          w_state_nxt = c_LOCK;
          w_owner_nxt = w_pick_idle;
          w_cnt_nxt   = '0;
        end
      end
      c_LOCK: begin
        if (fire) begin
          w_cnt_nxt = w_cnt_inc;
          if (tail) begin
            w_state_nxt = c_IDLE;
            w_ptr_nxt   = w_ptr_rel;
`ifdef OARB_BYPASS_EN
            if (|w_others) begin
              w_state_nxt = c_LOCK;
              w_owner_nxt = w_pick_byp;
              w_cnt_nxt   = '0;
            end
`endif
          end
        end else if (~|(req & w_own_oh)) begin
          // Owner withdrew mid-packet without a tail: abort and flag it.
          w_state_nxt = c_IDLE;
          w_ptr_nxt   = w_ptr_rel;
          w_err_nxt   = 1'b1;
        end
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Outputs: grant derived from state so an async reset drops it at once.
  always_comb begin
    lock     = (r_state == c_LOCK);
    grt      = lock ? w_own_oh : '0;
    owner    = r_owner;
    flit_cnt = r_cnt;
    err      = r_err;
  end

endmodule

`default_nettype wire
